// File: rtl/atm_txn_issuer.sv
// Purpose : card-session transaction sequencer in front of the ATM core; one request in flight at a time.
// Latency : request handshake at T -> core op at T+1 -> resp_valid at T+2+RESP_LATENCY (illegal op: T+1).
// Backpressure: req_ready is high only in SESSION; nothing is accepted while a transaction is in flight or locked.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   sess_*             session open (start + card/pin/expiry) and close (sess_end)
//   req_*              request channel (valid/ready, op, amount, aux)
//   resp_*             one-cycle result pulse with declined flag and echoed op
//   session_active, locked, timeout_pulse   session status
//   atm_*              drive/sample signals of the ATM core
module atm_txn_issuer #(
   parameter int RESP_LATENCY = 1,
   parameter int MAX_DECLINES = 3,
   parameter int IDLE_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sess_start,
   input  logic [9:0]  sess_card_no,
   input  logic [9:0]  sess_pin,
   input  logic [10:0] sess_expiry,
   input  logic        sess_end,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [9:0]  req_amount,
   input  logic [9:0]  req_aux,
   output logic        resp_valid,
   output logic        resp_declined,
   output logic [2:0]  resp_op,
   output logic        session_active,
   output logic        locked,
   output logic        timeout_pulse,
   output logic [2:0]  atm_operation,
   output logic [9:0]  atm_card_no,
   output logic [9:0]  atm_card_pin,
   output logic [10:0] atm_expiry_date,
   output logic [9:0]  atm_withdraw_amount,
   output logic [9:0]  atm_deposit_money,
   output logic [9:0]  atm_transfer_amount,
   output logic [9:0]  atm_transfer_no,
   output logic [9:0]  atm_new_pin,
   input  logic        atm_card_declined
);

   typedef enum logic [2:0] {
      S_IDLE, S_SESSION, S_ISSUE, S_WAIT, S_RESP, S_LOCKED
   } state_t;

   localparam logic [7:0] TMO_LIM   = 8'(IDLE_TIMEOUT);
   localparam logic [3:0] DEC_LIM   = 4'(MAX_DECLINES);
   localparam logic [3:0] WAIT_LAST = 4'(RESP_LATENCY - 1);

   state_t      state_q, state_d;
   logic [9:0]  card_q, card_d, pin_q, pin_d;
   logic [10:0] exp_q, exp_d;
   logic [2:0]  op_q, op_d;
   logic [9:0]  amt_q, amt_d, aux_q, aux_d;
   logic        flag_q, flag_d;         // accumulated decline for the in-flight txn
   logic        illegal_q, illegal_d;   // op 000/111: bypassed core, counter untouched
   logic        end_pend_q, end_pend_d; // sess_end seen while a txn was in flight
   logic [2:0]  dec_q, dec_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [3:0]  wait_q, wait_d;
   logic        tmo_pulse_q, tmo_pulse_d;

   logic        legal_op;
   logic        close;
   logic [3:0]  dec_inc;
   logic [7:0]  tmo_inc;

   assign legal_op = (req_op != 3'b000) && (req_op != 3'b111);

   always_comb begin
      state_d     = state_q;
      card_d      = card_q;
      pin_d       = pin_q;
      exp_d       = exp_q;
      op_d        = op_q;
      amt_d       = amt_q;
      aux_d       = aux_q;
      flag_d      = flag_q;
      illegal_d   = illegal_q;
      end_pend_d  = end_pend_q;
      dec_d       = dec_q;
      tmo_d       = tmo_q;
      wait_d      = wait_q;
      tmo_pulse_d = 1'b0;
      close       = 1'b0;
      dec_inc     = {1'b0, dec_q} + 4'd1;
      tmo_inc     = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (sess_start) begin
               card_d  = sess_card_no;
               pin_d   = sess_pin;
               exp_d   = sess_expiry;
               state_d = S_SESSION;
            end
         end
         S_SESSION: begin
            if (sess_end) begin
               close = 1'b1;
            end else if (req_valid) begin
               op_d      = req_op;
               amt_d     = req_amount;
               aux_d     = req_aux;
               tmo_d     = 8'd0;
               illegal_d = !legal_op;
               flag_d    = !legal_op;
               state_d   = legal_op ? S_ISSUE : S_RESP;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TMO_LIM) begin
                  close       = 1'b1;
                  tmo_pulse_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            flag_d  = atm_card_declined;
            wait_d  = 4'd0;
            state_d = S_WAIT;
            if (sess_end) end_pend_d = 1'b1;
         end
         S_WAIT: begin
            flag_d = flag_q | atm_card_declined;
            if (sess_end) end_pend_d = 1'b1;
            if (wait_q == WAIT_LAST) state_d = S_RESP;
            else wait_d = wait_q + 4'd1;
         end
         S_RESP: begin
            state_d = S_SESSION;
            if (!illegal_q) begin
               if (flag_q) begin
                  dec_d = dec_inc[2:0];
                  if (dec_inc >= DEC_LIM) state_d = S_LOCKED;
               end else begin
                  dec_d = 3'd0;
                  if (op_q == 3'b101) pin_d = aux_q;
               end
            end
            // A pending or same-cycle close overrides both SESSION and LOCKED.
            if (end_pend_q || sess_end) close = 1'b1;
         end
         S_LOCKED: begin
            if (sess_end) close = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (close) begin
         state_d    = S_IDLE;
         card_d     = 10'd0;
         pin_d      = 10'd0;
         exp_d      = 11'd0;
         dec_d      = 3'd0;
         tmo_d      = 8'd0;
         end_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         card_q      <= '0;
         pin_q       <= '0;
         exp_q       <= '0;
         op_q        <= '0;
         amt_q       <= '0;
         aux_q       <= '0;
         flag_q      <= 1'b0;
         illegal_q   <= 1'b0;
         end_pend_q  <= 1'b0;
         dec_q       <= '0;
         tmo_q       <= '0;
         wait_q      <= '0;
         tmo_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         card_q      <= card_d;
         pin_q       <= pin_d;
         exp_q       <= exp_d;
         op_q        <= op_d;
         amt_q       <= amt_d;
         aux_q       <= aux_d;
         flag_q      <= flag_d;
         illegal_q   <= illegal_d;
         end_pend_q  <= end_pend_d;
         dec_q       <= dec_d;
         tmo_q       <= tmo_d;
         wait_q      <= wait_d;
         tmo_pulse_q <= tmo_pulse_d;
      end
   end

   always_comb begin
      req_ready           = (state_q == S_SESSION);
      resp_valid          = (state_q == S_RESP);
      resp_declined       = (state_q == S_RESP) && flag_q;
      resp_op             = (state_q == S_RESP) ? op_q : 3'b000;
      session_active      = (state_q != S_IDLE);
      locked              = (state_q == S_LOCKED);
      timeout_pulse       = tmo_pulse_q;
      atm_card_no         = card_q;
      atm_card_pin        = pin_q;
      atm_expiry_date     = exp_q;
      atm_operation       = 3'b000;
      atm_withdraw_amount = 10'd0;
      atm_deposit_money   = 10'd0;
      atm_transfer_amount = 10'd0;
      atm_transfer_no     = 10'd0;
      atm_new_pin         = 10'd0;
      if (state_q == S_ISSUE) begin
         atm_operation = op_q;
         case (op_q)
            3'b010: atm_withdraw_amount = amt_q;
            3'b110: atm_deposit_money   = amt_q;
            3'b011: begin
               atm_transfer_amount = amt_q;
               atm_transfer_no     = aux_q;
            end
            3'b101: atm_new_pin = aux_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_txn_issuer.sv
module tb_atm_txn_issuer;
   localparam int RL   = 1;
   localparam int MAXD = 3;
   localparam int TMO  = 255;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, sess_start, sess_end, req_valid, atm_card_declined;
   logic [9:0]  sess_card_no, sess_pin, req_amount, req_aux;
   logic [10:0] sess_expiry;
   logic [2:0]  req_op;
   logic        req_ready, resp_valid, resp_declined, session_active, locked, timeout_pulse;
   logic [2:0]  resp_op, atm_operation;
   logic [9:0]  atm_card_no, atm_card_pin, atm_withdraw_amount, atm_deposit_money;
   logic [9:0]  atm_transfer_amount, atm_transfer_no, atm_new_pin;
   logic [10:0] atm_expiry_date;

   atm_txn_issuer #(.RESP_LATENCY(RL), .MAX_DECLINES(MAXD), .IDLE_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .sess_start(sess_start), .sess_card_no(sess_card_no), .sess_pin(sess_pin),
      .sess_expiry(sess_expiry), .sess_end(sess_end),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_amount(req_amount), .req_aux(req_aux),
      .resp_valid(resp_valid), .resp_declined(resp_declined), .resp_op(resp_op),
      .session_active(session_active), .locked(locked), .timeout_pulse(timeout_pulse),
      .atm_operation(atm_operation), .atm_card_no(atm_card_no), .atm_card_pin(atm_card_pin),
      .atm_expiry_date(atm_expiry_date), .atm_withdraw_amount(atm_withdraw_amount),
      .atm_deposit_money(atm_deposit_money), .atm_transfer_amount(atm_transfer_amount),
      .atm_transfer_no(atm_transfer_no), .atm_new_pin(atm_new_pin),
      .atm_card_declined(atm_card_declined)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Session-level reference model
   bit          m_open, m_locked;
   int          m_dec;
   logic [9:0]  m_card, m_pin;
   logic [10:0] m_exp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_close();
      m_open = 0; m_locked = 0; m_dec = 0;
      m_card = '0; m_pin = '0; m_exp = '0;
   endtask

   function automatic logic any_out();
      return |{req_ready, resp_valid, resp_declined, resp_op, session_active, locked,
               timeout_pulse, atm_operation, atm_card_no, atm_card_pin, atm_expiry_date,
               atm_withdraw_amount, atm_deposit_money, atm_transfer_amount,
               atm_transfer_no, atm_new_pin};
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_active"}, session_active, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_card"}, atm_card_no, 0);
      chk({tag, "_pin"}, atm_card_pin, 0);
      chk({tag, "_ready"}, req_ready, 0);
   endtask

   task automatic open_sess(input logic [9:0] card, input logic [9:0] pin, input logic [10:0] expd);
      sess_start = 1; sess_card_no = card; sess_pin = pin; sess_expiry = expd;
      step();
      sess_start = 0; sess_card_no = 10'($urandom); sess_pin = 10'($urandom);
      m_open = 1; m_locked = 0; m_dec = 0; m_card = card; m_pin = pin; m_exp = expd;
      chk("open_active", session_active, 1);
      chk("open_card", atm_card_no, m_card);
      chk("open_pin", atm_card_pin, m_pin);
      chk("open_expiry", atm_expiry_date, m_exp);
      chk("open_ready", req_ready, 1);
   endtask

   task automatic close_sess();
      sess_end = 1;
      step();
      sess_end = 0;
      model_close();
      check_idle("close");
   endtask

   // dmode: 0 random declines, 1 always decline, 2 never decline (inside the sampling window)
   task automatic txn(input logic [2:0] op, input logic [9:0] amt, input logic [9:0] aux,
                      input int dmode, input bit end_mid);
      bit legal, flag, got, dec;
      int lat_exp, nissue;
      legal   = (op != 3'b000) && (op != 3'b111);
      lat_exp = legal ? 2 + RL : 1;
      req_valid = 1; req_op = op; req_amount = amt; req_aux = aux;
      step();
      req_valid = 0; req_op = 3'($urandom); req_amount = 10'($urandom); req_aux = 10'($urandom);
      flag = !legal; got = 0; nissue = 0;
      for (int k = 1; k <= lat_exp + 4 && !got; k++) begin
         if (atm_operation != 3'b000) begin
            nissue++;
            chk("issue_cycle", k, 1);
            chk("issue_op", atm_operation, op);
            chk("wd_amt", atm_withdraw_amount, (op == 3'b010) ? amt : 10'd0);
            chk("dep_amt", atm_deposit_money, (op == 3'b110) ? amt : 10'd0);
            chk("xfer_amt", atm_transfer_amount, (op == 3'b011) ? amt : 10'd0);
            chk("xfer_no", atm_transfer_no, (op == 3'b011) ? aux : 10'd0);
            chk("new_pin", atm_new_pin, (op == 3'b101) ? aux : 10'd0);
         end else begin
            chk("quiet_fields", atm_withdraw_amount | atm_deposit_money | atm_transfer_amount
                                | atm_transfer_no | atm_new_pin, 0);
         end
         chk("ready_busy", req_ready, 0);
         if (resp_valid) begin
            got = 1;
            chk("resp_latency", k, lat_exp);
            chk("resp_declined", resp_declined, flag);
            chk("resp_op", resp_op, op);
            chk("pin_at_resp", atm_card_pin, m_pin);
         end
         if (legal && k >= 1 && k <= 1 + RL) begin
            dec = (dmode == 1) ? 1'b1 : (dmode == 2) ? 1'b0 : 1'($urandom);
            flag |= dec;
         end else begin
            dec = 1'($urandom);   // outside the sampling window: must be ignored
         end
         atm_card_declined = dec;
         sess_end = end_mid && (k == 2);
         if (!got) step();
      end
      sess_end = 0;
      if (!got) chk("resp_timeout", 0, 1);
      chk("issue_count", nissue, legal ? 1 : 0);
      if (legal) begin
         if (flag) m_dec++;
         else begin
            m_dec = 0;
            if (op == 3'b101) m_pin = aux;
         end
      end
      if (end_mid) model_close();
      else if (m_dec >= MAXD) m_locked = 1;
      step();
      atm_card_declined = 0;
      chk("post_resp_low", resp_valid, 0);
      chk("post_active", session_active, m_open);
      chk("post_locked", locked, m_locked);
      chk("post_ready", req_ready, m_open && !m_locked);
      chk("post_pin", atm_card_pin, m_pin);
      chk("post_card", atm_card_no, m_card);
   endtask

   task automatic measure_timeout();
      int cnt;
      cnt = -1;
      for (int k = 1; k <= TMO + 10; k++) begin
         step();
         if (timeout_pulse) begin
            cnt = k;
            break;
         end
      end
      chk("tmo_cycles", cnt, TMO);
      model_close();
      check_idle("tmo");
      step();
      chk("tmo_pulse_once", timeout_pulse, 0);
   endtask

   initial begin
      reset = 0; sess_start = 0; sess_end = 0; req_valid = 0; atm_card_declined = 0;
      sess_card_no = 0; sess_pin = 0; sess_expiry = 0; req_op = 0; req_amount = 0; req_aux = 0;
      model_close();
      step();
      step();
      chk("reset_outputs", any_out(), 0);
      reset = 1;
      step();
      chk("idle_outputs", any_out(), 0);

      // Balance enquiry, then sess_start inside a session is ignored
      open_sess(10'd100, 10'd100, 11'd1234);
      txn(3'b001, 10'd0, 10'd0, 2, 0);
      sess_start = 1; sess_card_no = 10'd5; sess_pin = 10'd6;
      step();
      sess_start = 0;
      chk("restart_ignored", atm_card_no, m_card);

      // Withdraw then deposit back to back, PIN change, transfer
      txn(3'b010, 10'd20, 10'd0, 2, 0);
      txn(3'b110, 10'd30, 10'd0, 2, 0);
      txn(3'b101, 10'd0, 10'd999, 2, 0);
      txn(3'b011, 10'd50, 10'd200, 2, 0);

      // Decline / success / decline must not lock; three straight declines lock
      txn(3'b001, 10'd0, 10'd0, 1, 0);
      txn(3'b001, 10'd0, 10'd0, 2, 0);
      txn(3'b001, 10'd0, 10'd0, 1, 0);
      txn(3'b100, 10'd0, 10'd0, 1, 0);
      txn(3'b010, 10'd7, 10'd0, 1, 0);
      chk("locked_now", locked, 1);
      req_valid = 1; req_op = 3'b001;
      step();
      step();
      req_valid = 0;
      chk("locked_no_op", atm_operation, 0);
      chk("locked_stays", locked, 1);
      close_sess();

      // Illegal ops neither increment nor clear the decline counter
      open_sess(10'd321, 10'd11, 11'd42);
      txn(3'b001, 10'd0, 10'd0, 1, 0);
      txn(3'b001, 10'd0, 10'd0, 1, 0);
      txn(3'b111, 10'd5, 10'd5, 0, 0);
      txn(3'b000, 10'd5, 10'd5, 0, 0);
      txn(3'b001, 10'd0, 10'd0, 1, 0);
      chk("lock_after_illegal", locked, 1);
      close_sess();

      // sess_end during WAIT still completes the transaction
      open_sess(10'd77, 10'd88, 11'd99);
      txn(3'b110, 10'd15, 10'd0, 0, 1);
      chk("end_mid_card", atm_card_no, 0);

      // sess_end wins over a simultaneous handshake
      open_sess(10'd78, 10'd89, 11'd98);
      req_valid = 1; req_op = 3'b010; req_amount = 10'd3; sess_end = 1;
      step();
      req_valid = 0; sess_end = 0;
      model_close();
      check_idle("end_vs_req");
      chk("end_vs_req_op", atm_operation, 0);
      step();
      chk("end_vs_req_resp", resp_valid, 0);

      // Idle timeout, and handshake restarts the timeout count
      open_sess(10'd500, 10'd501, 11'd502);
      measure_timeout();
      open_sess(10'd600, 10'd601, 11'd602);
      txn(3'b001, 10'd0, 10'd0, 2, 0);
      measure_timeout();

      // Randomised session traffic
      open_sess(10'($urandom), 10'($urandom), 11'($urandom));
      for (int i = 0; i < 60; i++) begin
         logic [2:0] op;
         bit em;
         op = 3'($urandom_range(0, 7));
         em = (op != 3'b000) && (op != 3'b111) && ($urandom_range(0, 9) == 0);
         txn(op, 10'($urandom), 10'($urandom), $urandom_range(0, 2), em);
         if (m_locked) close_sess();
         if (!m_open) open_sess(10'($urandom), 10'($urandom), 11'($urandom));
      end

      // Reset in the middle of WAIT aborts without a response
      req_valid = 1; req_op = 3'b010; req_amount = 10'd44;
      step();
      req_valid = 0;
      step();
      chk("rst_pre_wait_op", atm_operation, 0);
      reset = 0;
      step();
      reset = 1;
      chk("rst_mid_outputs", any_out(), 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rst_mid_no_resp", resp_valid | session_active, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
